// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t           - receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT - 50 MHz system clock at 115200 baud
//   UART_DATA_BITS       - payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 50_000_000 / 115200;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous input.
// The flops reset to 1 so an idle-high line never looks like activity
// while the chain fills after reset.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output, STAGES clocks behind d
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8-N-1 UART receiver with synchronizer, start-bit glitch rejection,
// stop-bit framing check and break recovery. Good bytes are presented
// with a one-cycle done strobe; bad stop bits give a one-cycle frame_err.
// Optional even parity bit when UART_RX_PARITY_EN is defined, which adds
// the parity_err port.
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   serial     in  raw UART line, idle high, asynchronous
//   data       out last correctly framed byte (LSB received first)
//   done       out one-cycle strobe, data updated this cycle
//   frame_err  out one-cycle strobe, stop bit sampled low
//   busy       out receiver not in IDLE
//   parity_err out one-cycle strobe, parity mismatch (UART_RX_PARITY_EN only)
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | timing to mid start bit to confirm it is not a glitch
// DATA   | sampling eight data bits at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, strobing done or frame_err
// BREAK  | line stuck low after a framing error, waiting for idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      done,
  output logic                      frame_err,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  rx_state_t                 state_q, state_d;
  logic                      rx_s;
  logic [CW-1:0]             cnt_q;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      cnt_last;
  logic                      done_d;
  logic                      frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                      parity_q;
  logic                      parity_err_d;
`endif

  sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (serial),
    .q  (rx_s)
  );

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit must still be low at its midpoint, otherwise it was noise.
        if (cnt_q == CNT_HALF) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_last && (bit_idx_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (cnt_last) state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decisions are computed here and registered below so the
  // outputs come straight from flops.
  always_comb begin
    busy        = (state_q != IDLE);
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if ((state_q == STOP) && cnt_last) begin
      if (!rx_s) begin
        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      end else if (^{shift_q, parity_q}) begin
        parity_err_d = 1'b1;
`endif
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done      <= done_d;
      frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_err_d;
`endif
      if (done_d) data <= shift_q;

      case (state_q)
        START: begin
          bit_idx_q <= '0;
          cnt_q     <= (cnt_q == CNT_HALF) ? '0 : cnt_q + CNT_ONE;
        end
        DATA: begin
          if (cnt_last) begin
            // LSB arrives first; shifting right leaves it in bit 0.
            shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + BIT_ONE;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            parity_q <= rx_s;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          cnt_q <= cnt_last ? '0 : cnt_q + CNT_ONE;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Honours UART_RX_PARITY_EN when defined (adds an even-parity bit to every
// frame and exercises parity_err).
module tb_uart_rx_frame;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 155 + CPB;
`else
  localparam int EXP_LAT = 155;
`endif

  logic       clk;
  logic       rst;
  logic       serial;
  logic [7:0] data;
  logic       done;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial   (serial),
    .data     (data),
    .done     (done),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: free-running counts of strobes, sampled on the falling edge.
  int         cyc = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         overlap_cnt = 0;
  int         done_run = 0;
  int         ferr_run = 0;
  int         max_done_run = 0;
  int         max_ferr_run = 0;
  int         last_done_cyc = 0;
  logic [7:0] last_done_data = 8'h00;
  int         fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      if (done_run == 0) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_done_data = data;
      end
      done_run++;
      if (done_run > max_done_run) max_done_run = done_run;
    end else begin
      done_run = 0;
    end
    if (frame_err) begin
      if (ferr_run == 0) ferr_cnt++;
      ferr_run++;
      if (ferr_run > max_ferr_run) max_ferr_run = ferr_run;
    end else begin
      ferr_run = 0;
    end
    if (done && frame_err) overlap_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
    if (parity_err && (done || frame_err)) overlap_cnt++;
`endif
  end

  // Tasks start and end on a falling clock edge.
  task automatic send_data(input logic [7:0] b);
    serial = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_data(b);
`ifdef UART_RX_PARITY_EN
    serial = ^b;
    repeat (CPB) @(negedge clk);
`endif
    serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_data(b);
    serial = par;
    repeat (CPB) @(negedge clk);
    serial = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask
`endif

  int base_done;
  int base_ferr;
  int base_perr;
  int lat;

  initial begin
    rst    = 1'b1;
    serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, data}, 32'h00);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // 0xA5 single frame with latency measurement
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    chk("a5_done_count", done_cnt - base_done, 1);
    chk("a5_data", {24'h0, data}, 32'hA5);
    chk("a5_frame_err", ferr_cnt - base_ferr, 0);
    lat = last_done_cyc - fall_cyc;
    chk("a5_latency", lat, EXP_LAT);

    // back-to-back 0x00 then 0xFF, no idle between stop and next start
    base_done = done_cnt;
    send_frame(8'h00, 1'b1);
    chk("b2b_first_count", done_cnt - base_done, 1);
    chk("b2b_first_data", {24'h0, last_done_data}, 32'h00);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    chk("b2b_total_count", done_cnt - base_done, 2);
    chk("b2b_second_data", {24'h0, data}, 32'hFF);

    // 4-cycle glitch on idle line
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    serial = 1'b0;
    repeat (4) @(negedge clk);
    serial = 1'b1;
    chk("glitch_busy_hi", {31'h0, busy}, 32'h1);
    repeat (7) @(negedge clk);
    chk("glitch_busy_back", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("glitch_no_done", done_cnt - base_done, 0);
    chk("glitch_no_ferr", ferr_cnt - base_ferr, 0);
    chk("glitch_data", {24'h0, data}, 32'hFF);

    // 0x3C with low stop bit, line held low 3 more bit times, then 0x12
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("ferr_busy_in_break", {31'h0, busy}, 32'h1);
    serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_count", ferr_cnt - base_ferr, 1);
    chk("ferr_no_done", done_cnt - base_done, 0);
    chk("ferr_data_kept", {24'h0, data}, 32'hFF);
    chk("ferr_busy_idle", {31'h0, busy}, 32'h0);
    send_frame(8'h12, 1'b1);
    repeat (10) @(negedge clk);
    chk("after_ferr_done", done_cnt - base_done, 1);
    chk("after_ferr_data", {24'h0, data}, 32'h12);

    // reset during bit 4 of 0x77, then 0x81
    base_done = done_cnt;
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial = (i == 3) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    serial = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("midrst_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_data", {24'h0, data}, 32'h00);
    repeat (2) @(negedge clk);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("midrst_no_report", done_cnt - base_done, 0);
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    chk("after_rst_done", done_cnt - base_done, 1);
    chk("after_rst_data", {24'h0, data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x03 has even weight, so parity bit must be 0
    base_done = done_cnt;
    base_perr = perr_cnt;
    send_frame_par(8'h03, 1'b1);
    repeat (10) @(negedge clk);
    chk("par_bad_perr", perr_cnt - base_perr, 1);
    chk("par_bad_no_done", done_cnt - base_done, 0);
    chk("par_bad_data", {24'h0, data}, 32'h81);
    send_frame_par(8'h03, 1'b0);
    repeat (10) @(negedge clk);
    chk("par_good_done", done_cnt - base_done, 1);
    chk("par_good_perr", perr_cnt - base_perr, 1);
    chk("par_good_data", {24'h0, data}, 32'h03);
`else
    base_perr = perr_cnt;
    chk("no_parity_strobes", base_perr, 0);
`endif

    chk("done_pulse_width", max_done_run, 1);
    chk("ferr_pulse_width", max_ferr_run, 1);
    chk("strobe_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
